// File: rtl/ucie_ctl_sb_rx_deser.sv
// Sideband RX deserializer: assembles LSB-first 32-bit words per packet, enforces stall timeout and inter-packet gap.
// Optional packet counter output o_pkt_count enabled by defining UCIE_CTL_SB_RX_DESER_STATS_EN.
module ucie_ctl_sb_rx_deser #(
  parameter int P_GAP_CYCLES     = 32,
  parameter int P_TIMEOUT_CYCLES = 8,
  parameter int P_WORDS          = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sb_data,
  input  logic        i_sb_vld,
  input  logic        i_cfg_crd,
  output logic        o_pl_cfg_vld,
  output logic [31:0] o_received_data,
  output logic        o_count_done,
  output logic        o_overrun_error,
  output logic        o_timeout_error,
  output logic        o_gap_error
`ifdef UCIE_CTL_SB_RX_DESER_STATS_EN
  ,
  output logic [15:0] o_pkt_count
`endif
);

  localparam int STALL_W = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam int GAP_W   = $clog2(P_GAP_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(P_TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LIMIT   = GAP_W'(P_GAP_CYCLES);
  localparam logic [1:0]         WORD_LAST   = 2'(P_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        shift_q, shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]         word_cnt_q, word_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               pl_cfg_vld_q, pl_cfg_vld_d;
  logic [31:0]        rx_data_q, rx_data_d;
  logic               count_done_q, count_done_d;
  logic               overrun_err_q, overrun_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic               gap_err_q, gap_err_d;

  logic [31:0]        word_full_s;
  logic [STALL_W-1:0] stall_inc_s;
  logic [GAP_W-1:0]   gap_inc_s;

  // New bits enter at the MSB so the first received bit ends up at bit 0
  assign word_full_s = {i_sb_data, shift_q[31:1]};
  assign stall_inc_s = stall_cnt_q + STALL_W'(1);
  assign gap_inc_s   = gap_cnt_q + GAP_W'(1);

  // Next-state, datapath and output-pulse computation
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rx_data_d     = rx_data_q;
    pl_cfg_vld_d  = 1'b0;
    count_done_d  = 1'b0;
    overrun_err_d = 1'b0;
    timeout_err_d = 1'b0;
    gap_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_sb_vld) begin
          shift_d     = {i_sb_data, 31'd0};
          bit_cnt_d   = 5'd1;
          word_cnt_d  = 2'd0;
          stall_cnt_d = '0;
          if (i_cfg_crd) begin
            pl_cfg_vld_d = 1'b1;
            state_d      = ST_SHIFT;
          end else begin
            overrun_err_d = 1'b1;
            state_d       = ST_DISCARD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT, ST_DISCARD: begin
        if (i_sb_vld) begin
          // An arriving bit always beats a stall count that would hit its limit
          shift_d     = word_full_s;
          stall_cnt_d = '0;
          if (bit_cnt_q == 5'd31) begin
            bit_cnt_d  = 5'd0;
            word_cnt_d = word_cnt_q + 2'd1;
            if (state_q == ST_SHIFT) begin
              rx_data_d    = word_full_s;
              count_done_d = 1'b1;
            end else begin
              rx_data_d = rx_data_q;
            end
            if (word_cnt_q == WORD_LAST) begin
              word_cnt_d = 2'd0;
              gap_cnt_d  = '0;
              state_d    = ST_GAP;
            end else begin
              state_d = state_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (stall_inc_s == STALL_LIMIT) begin
          timeout_err_d = 1'b1;
          shift_d       = 32'd0;
          bit_cnt_d     = 5'd0;
          word_cnt_d    = 2'd0;
          stall_cnt_d   = '0;
          state_d       = ST_IDLE;
        end else begin
          stall_cnt_d = stall_inc_s;
        end
      end

      ST_GAP: begin
        if (i_sb_vld) begin
          gap_err_d = 1'b1;
          gap_cnt_d = '0;
        end else if (gap_inc_s == GAP_LIMIT) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_inc_s;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= ST_IDLE;
      shift_q       <= 32'd0;
      bit_cnt_q     <= 5'd0;
      word_cnt_q    <= 2'd0;
      stall_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      rx_data_q     <= 32'd0;
      pl_cfg_vld_q  <= 1'b0;
      count_done_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      gap_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rx_data_q     <= rx_data_d;
      pl_cfg_vld_q  <= pl_cfg_vld_d;
      count_done_q  <= count_done_d;
      overrun_err_q <= overrun_err_d;
      timeout_err_q <= timeout_err_d;
      gap_err_q     <= gap_err_d;
    end
  end

  assign o_pl_cfg_vld    = pl_cfg_vld_q;
  assign o_received_data = rx_data_q;
  assign o_count_done    = count_done_q;
  assign o_overrun_error = overrun_err_q;
  assign o_timeout_error = timeout_err_q;
  assign o_gap_error     = gap_err_q;

`ifdef UCIE_CTL_SB_RX_DESER_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;

  // Saturating count of packets whose final word completed in SHIFT
  always_comb begin
    pkt_count_d = pkt_count_q;
    if ((state_q == ST_SHIFT) && i_sb_vld && (bit_cnt_q == 5'd31) &&
        (word_cnt_q == WORD_LAST) && (pkt_count_q != 16'hFFFF)) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // Packet counter register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pkt_count_q <= 16'd0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign o_pkt_count = pkt_count_q;
`endif

endmodule

// File: doc/ucie_ctl_sb_rx_deser.md
Name: ucie_ctl_sb_rx_deser

Overview:
Sideband receive deserializer. It sits directly upstream of the sideband RX message FSM.
- Samples the serial sideband bit stream and assembles four 32-bit phase words per packet.
- Raises the packet-start strobe and a per-word done pulse; the RX FSM decodes the words.
- Enforces the inter-packet idle gap and the mid-packet stall timeout, and drops packets that arrive while the FSM holds no credit.

Parameters:
P_GAP_CYCLES, 32, minimum consecutive i_sb_vld-low cycles required between packets.
P_TIMEOUT_CYCLES, 8, consecutive i_sb_vld-low cycles mid-packet that abort the packet.
P_WORDS, 4, 32-bit words per packet (phase_0..phase_3).

Ports:
i_clk  in  1  sideband clock; single clock domain.
i_rst  in  1  asynchronous, active-low reset.
i_sb_data  in  1  serial sideband bit, valid when i_sb_vld=1.
i_sb_vld  in  1  bit strobe; one bit accepted per cycle with i_sb_vld=1.
i_cfg_crd  in  1  credit from the RX FSM; 1 = FSM idle and able to accept a packet.
o_pl_cfg_vld  out  1  one-cycle packet-start pulse to the RX FSM.
o_received_data  out  32  last completed word; bit k = k-th received bit (LSB first).
o_count_done  out  1  one-cycle pulse; o_received_data holds a new word.
o_overrun_error  out  1  one-cycle pulse: packet start seen with i_cfg_crd=0.
o_timeout_error  out  1  one-cycle pulse: mid-packet stall reached P_TIMEOUT_CYCLES.
o_gap_error  out  1  one-cycle pulse: i_sb_vld=1 during the inter-packet gap.

Behaviour:
- Reset (async, i_rst=0): state=IDLE; shift register, bit_cnt[4:0], word_cnt[1:0] and the stall/gap counters cleared. All outputs are registered and reset to 0, including o_received_data=0.
- States: IDLE, SHIFT, DISCARD, GAP.
- IDLE, i_sb_vld=1, i_cfg_crd=1:
  - Capture i_sb_data as bit0; bit_cnt=1, word_cnt=0.
  - o_pl_cfg_vld=1 next cycle, exactly one cycle; go to SHIFT.
- IDLE, i_sb_vld=1, i_cfg_crd=0:
  - o_overrun_error pulse next cycle; no o_pl_cfg_vld.
  - bit_cnt=1, word_cnt=0; go to DISCARD.
- SHIFT:
  - Each i_sb_vld=1 cycle shifts a bit in and increments bit_cnt; the stall counter clears on every accepted bit.
  - When bit 31 is accepted, the next cycle has o_received_data=word and o_count_done=1 for exactly one cycle. o_received_data holds until the next word completes.
  - bit_cnt wraps 31->0 and word_cnt increments. Completing word P_WORDS-1 goes to GAP.
  - Minimum word-to-word spacing is 32 cycles; o_count_done never pulses on consecutive cycles.
- DISCARD: counts bits exactly as SHIFT but never updates o_received_data or pulses o_count_done; after P_WORDS*32 bits go to GAP.
- Stall (SHIFT or DISCARD):
  - The stall counter increments each cycle with i_sb_vld=0.
  - On reaching P_TIMEOUT_CYCLES: o_timeout_error pulse, go to IDLE, counters cleared, partial word dropped (no o_count_done).
  - The downstream FSM is then recovered by the link-error handler, not by this block.
- GAP:
  - The gap counter increments on each i_sb_vld=0 cycle.
  - i_sb_vld=1 before P_GAP_CYCLES: o_gap_error pulse, bit ignored, gap counter restarts at 0, stay in GAP.
  - Reaching P_GAP_CYCLES: go to IDLE.
- Simultaneous events:
  - The stall counter reaching its limit in the same cycle a bit arrives: the bit wins; the counter clears and no timeout fires.
  - At most one error pulse per cycle.
- Reset asserted mid-packet: immediate return to reset values; no pulses generated on deassertion.

Optional Feature:
Macro UCIE_CTL_SB_RX_DESER_STATS_EN.
- Defined: adds output o_pkt_count [15:0], reset 0.
  - Increments when the final o_count_done of a SHIFT packet fires.
  - Saturates at 16'hFFFF; overrun, timeout and discarded packets are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Nominal packet: i_cfg_crd=1, send words 0x2000_401B, 0x0500_0000, 0xDEAD_BEEF, 0x1234_5678 LSB-first, continuous i_sb_vld.
  - Expect o_pl_cfg_vld one cycle after the first bit.
  - Expect four o_count_done pulses 32 cycles apart, each with the matching o_received_data; then GAP.
- Overrun: i_cfg_crd=0 at the first bit, send 128 bits.
  - Expect o_overrun_error=1 for one cycle.
  - Expect no o_pl_cfg_vld and no o_count_done; o_received_data unchanged.
- Stall timeout: send 40 bits, then hold i_sb_vld=0 for 8 cycles.
  - Expect one o_count_done (word0), then o_timeout_error after the 8th low cycle, then IDLE.
  - Next packet decodes correctly.
- Gap violation: after a full packet, assert i_sb_vld at gap cycle 10.
  - Expect o_gap_error pulse.
  - A new packet is accepted only after 32 further low cycles.
- Stall recovery and reset: in SHIFT, 7 low cycles then a bit -> no timeout. Then assert i_rst mid-word -> all outputs 0, state IDLE.
- Stats (macro defined): 3 good packets, 1 overrun, 1 timeout -> o_pkt_count=3.
